dft_result_spi_tx: RTL and testbench

- Transmit-side counterpart of the SPI sample path: snapshots the scaled DFT bin outputs when the DFT reports done, then serializes them to an external SPI master on MISO.
- SPI slave, mode 3 (CPOL=1, CPHA=1), MSB first.
- Sits beside the DFT core in the DFT/SPI top level; sclk and ss are sampled in the i_sys_clk domain.

---
 rtl/dft_result_spi_tx.sv | 155 +++++++++++++++
 tb/tb_dft_result_spi_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dft_result_spi_tx.sv
// Snapshots DFT bin outputs on i_done and shifts them out as an SPI mode-3 slave, MSB first.
// Optional frame header {4'hA, seq} is enabled with the DFT_TX_HEADER_EN macro.
module dft_result_spi_tx #(
  parameter int DFT_WIDTH = 16,
  parameter int BIN_NUM   = 1
) (
  input  logic                           i_sys_clk,
  input  logic                           i_sys_rst,
  input  logic [BIN_NUM*2*DFT_WIDTH-1:0] i_X,
  input  logic                           i_done,
  input  logic                           i_clr_ovr,
  input  logic                           i_ss,
  input  logic                           i_sclk,
  output logic                           o_miso,
  output logic                           o_valid,
  output logic                           o_busy,
  output logic                           o_frame_done,
  output logic                           o_overrun
);
  localparam int FRAME_BITS = BIN_NUM * 2 * DFT_WIDTH;
`ifdef DFT_TX_HEADER_EN
  localparam int HDR_BITS = 8;
`else
  localparam int HDR_BITS = 0;
`endif
  localparam int FLEN = FRAME_BITS + HDR_BITS;
  localparam int CW   = $clog2(FLEN + 1);
  localparam int XW   = 2 ** CW;

  typedef enum logic [1:0] {IDLE, LOADED, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sclk_q, ss_q;
  logic [FRAME_BITS-1:0]   snap_q, snap_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    miso_q, miso_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    ovr_q, ovr_d;
  logic [FRAME_BITS-1:0]   payload;
  logic [FLEN-1:0]         frame;
  logic [XW-1:0]           frame_ext;
  logic [CW-1:0]           bit_idx;
  logic                    sclk_fall, sclk_rise, ss_fall, ss_rise;

  // Word k of i_X (bin k/2, real then imag) goes out k-th, so it lands at the top of the frame.
  genvar gi;
  generate
    for (gi = 0; gi < 2 * BIN_NUM; gi++) begin : g_word
      assign payload[FRAME_BITS-1-gi*DFT_WIDTH -: DFT_WIDTH] = snap_q[(gi+1)*DFT_WIDTH-1 -: DFT_WIDTH];
    end
  endgenerate

`ifdef DFT_TX_HEADER_EN
  logic [3:0] seq_q, seq_d;
  assign frame = {4'hA, seq_q, payload};
`else
  assign frame = payload;
`endif

  assign frame_ext = {{(XW-FLEN){1'b0}}, frame};
  assign bit_idx   = CW'(FLEN - 1) - cnt_q;
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= IDLE;
      sclk_q  <= 3'b111;
      ss_q    <= 3'b111;
      snap_q  <= '0;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef DFT_TX_HEADER_EN
      seq_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      sclk_q  <= {sclk_q[1:0], i_sclk};
      ss_q    <= {ss_q[1:0], i_ss};
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      miso_q  <= miso_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
`ifdef DFT_TX_HEADER_EN
      seq_q   <= seq_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    miso_d  = miso_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q & ~i_clr_ovr;
`ifdef DFT_TX_HEADER_EN
    seq_d   = seq_q;
`endif
    case (state_q)
      IDLE, LOADED: begin
        miso_d = 1'b0;
        if (i_done) begin
          snap_d  = i_X;
          valid_d = 1'b1;
          state_d = LOADED;
        end
        if (ss_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (i_done) ovr_d = 1'b1;
        if (sclk_rise && cnt_q == CW'(FLEN)) begin
          // Snapshot is consumed; clearing it makes a later unloaded read return zeros.
          done_d  = 1'b1;
          valid_d = 1'b0;
          snap_d  = '0;
          miso_d  = 1'b0;
          state_d = IDLE;
`ifdef DFT_TX_HEADER_EN
          seq_d   = seq_q + 4'd1;
`endif
        end else if (ss_rise) begin
          miso_d  = 1'b0;
          state_d = valid_q ? LOADED : IDLE;
        end else if (sclk_fall) begin
          if (cnt_q < CW'(FLEN)) begin
            miso_d = frame_ext[bit_idx];
            cnt_d  = cnt_q + 1'b1;
          end else begin
            miso_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_miso       = miso_q;
  assign o_valid      = valid_q;
  assign o_busy       = (state_q == SHIFT);
  assign o_frame_done = done_q;
  assign o_overrun    = ovr_q;
endmodule

// File: tb/tb_dft_result_spi_tx.sv
// Randomized bench for dft_result_spi_tx: SPI mode-3 master plus a word-list reference model.
module tb_dft_result_spi_tx;
  localparam int W  = 16;
  localparam int BN = 2;
  localparam int FB = BN * 2 * W;
`ifdef DFT_TX_HEADER_EN
  localparam int FLEN = FB + 8;
`else
  localparam int FLEN = FB;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FB-1:0] x   = '0;
  logic          done = 1'b0, clr_ovr = 1'b0, ss = 1'b1, sclk = 1'b1;
  logic          miso, valid, busy, frame_done, overrun;

  int tests = 0;
  int fails = 0;
  int done_total = 0;

  // Reference model: the held words in transmit order, plus frame sequence number.
  logic [W-1:0] mw [4];
  logic         m_valid = 1'b0;
  logic [3:0]   m_seq = 4'd0;

  dft_result_spi_tx #(.DFT_WIDTH(W), .BIN_NUM(BN)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_X(x), .i_done(done), .i_clr_ovr(clr_ovr),
    .i_ss(ss), .i_sclk(sclk), .o_miso(miso), .o_valid(valid), .o_busy(busy),
    .o_frame_done(frame_done), .o_overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (frame_done) done_total++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [127:0] exp_frame(input logic v);
    logic [FB-1:0] p;
    p = v ? {mw[0], mw[1], mw[2], mw[3]} : '0;
`ifdef DFT_TX_HEADER_EN
    return 128'({4'hA, m_seq, p});
`else
    return 128'(p);
`endif
  endfunction

  function automatic logic [FB-1:0] pack_x(input logic [W-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic load(input logic [W-1:0] w0, w1, w2, w3);
    @(negedge clk);
    x = pack_x(w0, w1, w2, w3);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    mw[0] = w0; mw[1] = w1; mw[2] = w2; mw[3] = w3;
    m_valid = 1'b1;
  endtask

  // Called at a negedge; every delay is a multiple of the sys period so timing stays aligned.
  task automatic spi_read(input int nbits, output logic [127:0] rx);
    rx = '0;
    ss = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      #40;
      rx = {rx[126:0], miso};
      sclk = 1'b1;
      #40;
    end
    #60;
    ss = 1'b1;
    #100;
  endtask

  task automatic full_read(input string tag);
    logic [127:0] rx;
    int d0;
    d0 = done_total;
    @(negedge clk);
    spi_read(FLEN, rx);
    check({tag, "_data"}, rx, exp_frame(m_valid));
    check({tag, "_done"}, 128'(done_total - d0), 128'd1);
    check({tag, "_valid"}, 128'(valid), 128'd0);
    m_valid = 1'b0;
    m_seq++;
  endtask

  initial begin
    logic [127:0] rx, full;
    int d0;
    #1;
    check("reset_outputs", {123'd0, miso, valid, busy, frame_done, overrun}, 128'd0);
    #30;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Load and send
    load(16'h1234, 16'hFEDC, 16'h0001, 16'h8000);
    check("load_valid", 128'(valid), 128'd1);
    full_read("send");

    // Abort after 20 bits, then a complete resend
    load(16'h1234, 16'hFEDC, 16'h0001, 16'h8000);
    full = exp_frame(1'b1);
    d0 = done_total;
    @(negedge clk);
    spi_read(20, rx);
    check("abort_bits", rx, full >> (FLEN - 20));
    check("abort_nodone", 128'(done_total - d0), 128'd0);
    check("abort_valid", 128'(valid), 128'd1);
    full_read("resend");

    // Overrun during bit 10: frame unchanged, flag sticky until cleared
    load(16'h1234, 16'hFEDC, 16'h0001, 16'h8000);
    @(negedge clk);
    fork
      spi_read(FLEN, rx);
      begin
        #(100 + 10 * 80 + 20);
        x = pack_x(16'h5555, 16'hFEDC, 16'h0001, 16'h8000);
        done = 1'b1;
        #10;
        done = 1'b0;
      end
    join
    check("ovr_data", rx, exp_frame(1'b1));
    m_valid = 1'b0;
    m_seq++;
    check("ovr_flag", 128'(overrun), 128'd1);
    @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("ovr_cleared", 128'(overrun), 128'd0);
    full_read("empty");

    // Recapture: newest i_done wins
    load(16'h1111, 16'h0A0A, 16'h0B0B, 16'h0C0C);
    load(16'h2222, 16'h0A0A, 16'h0B0B, 16'h0C0C);
    full_read("recapture");

    // Randomized loads
    for (int k = 0; k < 6; k++) begin
      load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      full_read($sformatf("rand%0d", k));
    end

    // Overclocking: six extra edges shift zeros, one frame_done
    load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    full = exp_frame(1'b1);
    d0 = done_total;
    @(negedge clk);
    spi_read(FLEN + 6, rx);
    check("overclk_data", rx, full << 6);
    check("overclk_done", 128'(done_total - d0), 128'd1);
    m_valid = 1'b0;
    m_seq++;

    // Reset mid-frame: outputs clear without waiting for a clock edge
    load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    ss = 1'b0;
    #100;
    for (int i = 0; i < 30; i++) begin
      sclk = 1'b0; #40; sclk = 1'b1; #40;
    end
    sclk = 1'b0;
    #32;
    rst = 1'b1;
    #1;
    check("midreset_outputs", {123'd0, miso, valid, busy, frame_done, overrun}, 128'd0);
    ss = 1'b1;
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    m_seq = 4'd0;
    repeat (3) @(negedge clk);

`ifdef DFT_TX_HEADER_EN
    // Header sequence: abort between frames must not advance seq
    for (int k = 0; k < 3; k++) begin
      load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      if (k == 1) begin
        @(negedge clk);
        spi_read(12, rx);
        check("hdr_abort_bits", rx, exp_frame(1'b1) >> (FLEN - 12));
      end
      @(negedge clk);
      spi_read(FLEN, rx);
      check($sformatf("hdr%0d", k), 128'(rx[FLEN-1 -: 8]), 128'({4'hA, 4'(k)}));
      check($sformatf("hdr%0d_data", k), rx, exp_frame(1'b1));
      m_valid = 1'b0;
      m_seq++;
    end
`else
    full_read("after_reset");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
